random_seq_scheduler: RTL

Programmable sequencer that drives the 3-bit RandomCounter through an arbitrary user-loaded value sequence.
- Replaces the fixed combinational controller: holds a small sequence table and steps through it once or in a loop.
- Drives the counter's `in`/`clear` inputs and checks the counter's `count` feedback every step.
- Sits between a configuration host (table load, start/stop) and the counter datapath.

---
 rtl/random_seq_pkg.sv | 17 +
 rtl/random_seq_scheduler_seq_table.sv | 24 ++
 rtl/random_seq_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/random_seq_pkg.sv
// Shared types and size defaults for the programmable counter sequencer.
package random_seq_pkg;

  localparam int unsigned SEQ_WIDTH = 3;
  localparam int unsigned SEQ_DEPTH = 8;
  localparam int unsigned SEQ_PTR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [SEQ_WIDTH-1:0] entry_t;

endpackage

// File: rtl/random_seq_scheduler_seq_table.sv
// Sequence table: DEPTH x WIDTH register file, synchronous write, asynchronous read.
module seq_table #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the host reloads after power-up.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/random_seq_scheduler.sv
// Steps the 3-bit counter through a host-loaded value table and checks its feedback.
// Optional: define SEQ_ERR_HALT_EN to abort the sequence on the first mismatch.
module random_seq_scheduler
  import random_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned DEPTH = SEQ_DEPTH,
  parameter int unsigned PTR_W = SEQ_PTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [PTR_W-1:0] cfg_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] in,
  output logic             clear,
  output logic             busy,
  output logic             done,
  output logic             seq_err,
  output logic [PTR_W-1:0] step_idx
);

  state_t           state;
  logic [PTR_W-1:0] last;
  logic             loop_q;
  logic [WIDTH-1:0] exp;
  logic             chk_v;
  logic [WIDTH-1:0] rdata;
  logic             mismatch;
  logic             halt;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we & ~busy),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (step_idx),
    .rdata (rdata)
  );

  assign mismatch = chk_v && (count != exp);

`ifdef SEQ_ERR_HALT_EN
  assign halt = mismatch;
`else
  assign halt = 1'b0;
`endif

  // Moore decode; step_idx parks on last in CHK/DONE so the counter holds.
  assign clear = (state == IDLE);
  assign in    = (state == IDLE) ? '0 : rdata;
  assign busy  = (state == RUN) || (state == CHK);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      step_idx <= '0;
      last     <= '0;
      loop_q   <= 1'b0;
      exp      <= '0;
      chk_v    <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (mismatch) seq_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            step_idx <= '0;
            seq_err  <= 1'b0;
            last     <= cfg_last;
            loop_q   <= loop_en;
          end
        end
        RUN: begin
          exp   <= rdata;
          chk_v <= 1'b1;
          if (stop || halt) begin
            state <= IDLE;
            chk_v <= 1'b0;
          end else if (step_idx == last) begin
            if (loop_q) step_idx <= '0;
            else        state    <= CHK;
          end else begin
            step_idx <= step_idx + PTR_W'(1);
          end
        end
        CHK: begin
          if (stop || halt) begin
            state <= IDLE;
            chk_v <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          chk_v <= 1'b0;
        end
        default: begin
          state <= IDLE;
          chk_v <= 1'b0;
        end
      endcase
    end
  end

endmodule
